// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the digit-serial multiplier sequencer.
package mult_seq_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // One core step per digit pair: (W/4)^2 steps in total.
  function automatic int steps_for(input int w);
    return (w / DIGIT_W) * (w / DIGIT_W);
  endfunction

endpackage

// File: rtl/multiplier.sv
// 4x4 unsigned multiplier core: four shifted partial-product rows reduced by addition.
module multiplier (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] PRODUCT,
  output logic       cout
);

  logic [8:0] pp0, pp1, pp2, pp3;
  logic [8:0] sum;

  always_comb begin
    pp0 = {5'd0, A & {4{B[0]}}};
    pp1 = {4'd0, A & {4{B[1]}}, 1'b0};
    pp2 = {3'd0, A & {4{B[2]}}, 2'b0};
    pp3 = {2'd0, A & {4{B[3]}}, 3'b0};
    sum = (pp0 + pp1) + (pp2 + pp3);
  end

  // A 4x4 product fits in 8 bits, so cout is always 0.
  assign PRODUCT = sum[7:0];
  assign cout    = sum[8];

endmodule

// File: rtl/mult_seq_ctrl.sv
// W x W unsigned multiplier built by time-sharing one 4x4 core over (W/4)^2 cycles.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] PRODUCT,
  output logic           busy
);

  localparam int N      = W / DIGIT_W;
  localparam int STEPS  = steps_for(W);
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int AW     = 2 * W;

  state_t              state_q, state_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  int                  i_idx, j_idx;
  logic [DIGIT_W-1:0]  a_dig, b_dig;
  logic [7:0]          core_p;
  logic                core_cout;
  logic [AW-1:0]       pp_ext;
  logic [AW-1:0]       pp_shift;

  multiplier u_core (
    .A       (a_dig),
    .B       (b_dig),
    .PRODUCT (core_p),
    .cout    (core_cout)
  );

  always_comb begin
    i_idx    = int'(step_q) / N;
    j_idx    = int'(step_q) % N;
    a_dig    = a_q[DIGIT_W*i_idx +: DIGIT_W];
    b_dig    = b_q[DIGIT_W*j_idx +: DIGIT_W];
    // cout is folded in for completeness; it never carries a set bit.
    pp_ext   = AW'({core_cout, core_p});
    pp_shift = pp_ext << (DIGIT_W * (i_idx + j_idx));
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    step_d      = step_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = A;
          b_d        = B;
          acc_d      = '0;
          step_d     = '0;
          state_d    = CALC;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      CALC: begin
        acc_d  = acc_q + pp_shift;
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(STEPS - 1)) begin
          step_d      = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        // Result is held here under any length of backpressure; no new accept until IDLE.
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      step_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign PRODUCT   = acc_q;

endmodule
